vram_arbiter: RTL and testbench

- Responder side of the video fetch interface: owns the single-port 8K×8 screen RAM.
- Serves the video generator's timed reads (13-bit address, read strobe, busy window).
- Arbitrates CPU reads and writes into the free slots, with a 1-entry posted write buffer and a req/ack handshake.
- Sits between the video generator, the CPU memory decode (0x4000–0x5FFF window) and the screen BRAM.

---
 rtl/vram_arbiter_pkg.sv | 22 ++
 rtl/vram_wbuf.sv | 51 +++++
 rtl/vram_arbiter.sv | 153 +++++++++++++++
 tb/tb_vram_arbiter.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vram_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vram_arbiter_pkg                                                      |
// | Shared widths, screen page base and arbiter FSM states.               |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package vram_arbiter_pkg;

   localparam int          c_ADDR_W      = 13;
   localparam int          c_DATA_W      = 8;
   localparam logic [15:0] c_SCREEN_BASE = 16'h4000;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_WR_WAIT  = 3'd1,
      ST_RD_ISSUE = 3'd2,
      ST_RD_DATA  = 3'd3,
      ST_ACK      = 3'd4
   } arbState_t;

endpackage
`default_nettype wire

// File: rtl/vram_wbuf.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vram_wbuf                                                             |
// | One-entry posted write buffer with load, drain and address match.     |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module vram_wbuf
   import vram_arbiter_pkg::*;
#(
   parameter int AW = c_ADDR_W,
   parameter int DW = c_DATA_W
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          load,
   input  logic          drain,
   input  logic [AW-1:0] loadAddr,
   input  logic [DW-1:0] loadData,
   input  logic [AW-1:0] matchAddr,
   output logic          valid,
   output logic [AW-1:0] bufAddr,
   output logic [DW-1:0] bufData,
   output logic          match
);

   logic          r_valid;
   logic [AW-1:0] r_addr;
   logic [DW-1:0] r_data;

   // A load on the same edge as a drain refills the slot just emptied.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_valid <= 1'b0;
         r_addr  <= '0;
         r_data  <= '0;
      end else if (load) begin
         r_valid <= 1'b1;
         r_addr  <= loadAddr;
         r_data  <= loadData;
      end else if (drain) begin
         r_valid <= 1'b0;
      end
   end

   assign valid   = r_valid;
   assign bufAddr = r_addr;
   assign bufData = r_data;
   assign match   = r_valid && (r_addr == matchAddr);

endmodule
`default_nettype wire

// File: rtl/vram_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vram_arbiter                                                          |
// | Screen RAM owner: video fetch has absolute priority, CPU uses gaps.   |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module vram_arbiter
   import vram_arbiter_pkg::*;
#(
   parameter int AW = c_ADDR_W,
   parameter int DW = c_DATA_W
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          video_busy,
   input  logic          video_read,
   input  logic [AW-1:0] video_a,
   output logic [DW-1:0] video_d,
   input  logic          cpu_req,
   input  logic          cpu_wr,
   input  logic [AW-1:0] cpu_a,
   input  logic [DW-1:0] cpu_d,
   output logic [DW-1:0] cpu_q,
   output logic          cpu_ack,
   output logic [AW-1:0] ram_a,
   output logic          ram_we,
   output logic [DW-1:0] ram_d,
   input  logic [DW-1:0] ram_q
);

   arbState_t     r_state;
   logic          r_cpuAck;
   logic [DW-1:0] r_cpuQ;
   logic          r_armed;
   logic [15:0]   r_videoFetches;

   logic          w_bufValid;
   logic          w_bufMatch;
   logic [AW-1:0] w_bufAddr;
   logic [DW-1:0] w_bufData;
   logic          w_drain;
   logic          w_bufFree;
   logic          w_accept;
   logic          w_load;

   assign w_drain   = video_busy & w_bufValid;
   assign w_bufFree = ~w_bufValid | w_drain;
   assign w_accept  = (r_state == ST_IDLE) & cpu_req & r_armed;
   assign w_load    = w_bufFree & ((w_accept & cpu_wr) | (r_state == ST_WR_WAIT));

   vram_wbuf #(
      .AW(AW),
      .DW(DW)
   ) u_wbuf (
      .clock     (clock),
      .reset     (reset),
      .load      (w_load),
      .drain     (w_drain),
      .loadAddr  (cpu_a),
      .loadData  (cpu_d),
      .matchAddr (cpu_a),
      .valid     (w_bufValid),
      .bufAddr   (w_bufAddr),
      .bufData   (w_bufData),
      .match     (w_bufMatch)
   );

   // Port ownership follows video_busy combinationally; a CPU access cut off
   // by a falling video_busy simply did not happen and is retried.
   always_comb begin
      ram_a  = cpu_a;
      ram_we = 1'b0;
      ram_d  = w_bufData;
      if (!video_busy) begin
         ram_a = video_a;
      end else if (w_bufValid) begin
         ram_a  = w_bufAddr;
         ram_we = 1'b1;
      end
   end

   assign video_d = ram_q;
   assign cpu_q   = r_cpuQ;
   assign cpu_ack = r_cpuAck;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state        <= ST_IDLE;
         r_cpuAck       <= 1'b0;
         r_cpuQ         <= '0;
         r_armed        <= 1'b1;
         r_videoFetches <= '0;
      end else begin
         if (video_read) begin
            r_videoFetches <= r_videoFetches + 16'd1;
         end
         r_cpuAck <= 1'b0;
         case (r_state)
            // A request is taken only after cpu_req was seen low in IDLE.
            ST_IDLE: begin
               if (!cpu_req) begin
                  r_armed <= 1'b1;
               end else if (r_armed) begin
                  r_armed <= 1'b0;
                  if (cpu_wr) begin
                     if (w_bufFree) begin
                        r_state  <= ST_ACK;
                        r_cpuAck <= 1'b1;
                     end else begin
                        r_state <= ST_WR_WAIT;
                     end
                  end else if (w_bufMatch) begin
                     r_cpuQ   <= w_bufData;
                     r_state  <= ST_ACK;
                     r_cpuAck <= 1'b1;
                  end else begin
                     r_state <= ST_RD_ISSUE;
                  end
               end
            end
            ST_WR_WAIT: begin
               if (w_bufFree) begin
                  r_state  <= ST_ACK;
                  r_cpuAck <= 1'b1;
               end
            end
            // The buffered write must reach RAM before a read can be issued.
            ST_RD_ISSUE: begin
               if (w_bufMatch) begin
                  r_cpuQ   <= w_bufData;
                  r_state  <= ST_ACK;
                  r_cpuAck <= 1'b1;
               end else if (video_busy && !w_bufValid) begin
                  r_state <= ST_RD_DATA;
               end
            end
            ST_RD_DATA: begin
               r_cpuQ   <= ram_q;
               r_state  <= ST_ACK;
               r_cpuAck <= 1'b1;
            end
            ST_ACK: begin
               r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_vram_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_vram_arbiter                                                       |
// | Directed vectors, corner sequences and random traffic vs. a model.    |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_vram_arbiter;
   import vram_arbiter_pkg::*;

   localparam int TIMEOUT = 1000;
   localparam int LINES   = 40;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        video_busy = 1'b1;
   logic        video_read = 1'b0;
   logic [12:0] video_a = '0;
   logic [7:0]  video_d;
   logic        cpu_req = 1'b0;
   logic        cpu_wr = 1'b0;
   logic [12:0] cpu_a = '0;
   logic [7:0]  cpu_d = '0;
   logic [7:0]  cpu_q;
   logic        cpu_ack;
   logic [12:0] ram_a;
   logic        ram_we;
   logic [7:0]  ram_d;
   logic [7:0]  ram_q;

   int          nChecks = 0;
   int          nErrors = 0;
   logic [7:0]  bram   [8192];
   logic [7:0]  golden [8192];
   logic [20:0] ramLog [$];
   logic [20:0] issued [$];
   bit          monEn = 1'b0;
   bit          videoDone = 1'b0;
   logic        monPrevBusy;
   logic [7:0]  monExp;

   typedef struct {
      bit          busy;
      bit          wr;
      logic [12:0] a;
      logic [7:0]  d;
      int          lat;
      logic [7:0]  q;
   } vec_t;

   always #5 clock = ~clock;

   vram_arbiter dut (
      .clock      (clock),
      .reset      (reset),
      .video_busy (video_busy),
      .video_read (video_read),
      .video_a    (video_a),
      .video_d    (video_d),
      .cpu_req    (cpu_req),
      .cpu_wr     (cpu_wr),
      .cpu_a      (cpu_a),
      .cpu_d      (cpu_d),
      .cpu_q      (cpu_q),
      .cpu_ack    (cpu_ack),
      .ram_a      (ram_a),
      .ram_we     (ram_we),
      .ram_d      (ram_d),
      .ram_q      (ram_q)
   );

   function automatic logic [7:0] initVal(input logic [12:0] a);
      return a[7:0] ^ 8'hC3;
   endfunction

   task automatic checkEq(input string name, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act !== exp) begin
         nErrors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Screen BRAM: synchronous read, write log for ordering checks.
   always @(posedge clock) begin
      if (ram_we === 1'b1) begin
         bram[ram_a] <= ram_d;
         ramLog.push_back({ram_a, ram_d});
      end
      ram_q       <= bram[ram_a];
      monPrevBusy <= video_busy;
      monExp      <= bram[video_a];
   end

   always @(negedge clock) begin
      if (monEn) begin
         if (video_busy === 1'b0) begin
            checkEq("video_we", 32'(ram_we), 32'd0);
            checkEq("video_addr", 32'(ram_a), 32'(video_a));
         end
         if (monPrevBusy === 1'b0) begin
            checkEq("video_data", 32'(video_d), 32'(monExp));
         end
      end
   end

   // Called just after a rising edge; returns just after a rising edge.
   task automatic cpuOp(input bit wr, input logic [12:0] a, input logic [7:0] d,
                        output int lat, output logic [7:0] q, output bit ok);
      lat = 0;
      q   = 8'h00;
      ok  = 1'b0;
      cpu_req = 1'b1;
      cpu_wr  = wr;
      cpu_a   = a;
      cpu_d   = d;
      for (int i = 0; i < TIMEOUT; i++) begin
         @(posedge clock);
         lat++;
         @(negedge clock);
         if (cpu_ack === 1'b1) begin
            ok = 1'b1;
            q  = cpu_q;
            break;
         end
      end
      @(posedge clock);
      #1 cpu_req = 1'b0;
      @(posedge clock);
      #1;
   endtask

   task automatic doOp(input bit wr, input logic [12:0] a, input logic [7:0] d,
                       output int lat, output logic [7:0] q);
      bit ok;
      cpuOp(wr, a, d, lat, q, ok);
      checkEq("op_timeout", 32'(ok), 32'd1);
      if (ok && wr) begin
         golden[a] = d;
         issued.push_back({a, d});
      end
   endtask

   initial begin
      vec_t        tbl [9];
      int          lat;
      int          n;
      int          bad;
      int          sz;
      int          fetchCnt;
      logic [7:0]  q;
      bit          ok;

      for (int i = 0; i < 8192; i++) begin
         bram[i]   = initVal(13'(i));
         golden[i] = initVal(13'(i));
      end
      tbl[0] = '{1'b1, 1'b1, 13'h0123, 8'hA5, 1, 8'h00};
      tbl[1] = '{1'b1, 1'b0, 13'h0123, 8'h00, 3, 8'hA5};
      tbl[2] = '{1'b1, 1'b1, 13'h1FFF, 8'h5A, 1, 8'h00};
      tbl[3] = '{1'b1, 1'b0, 13'h1FFF, 8'h00, 3, 8'h5A};
      tbl[4] = '{1'b1, 1'b0, 13'h0000, 8'h00, 3, 8'hC3};
      tbl[5] = '{1'b0, 1'b1, 13'h0040, 8'h3C, 1, 8'h00};
      tbl[6] = '{1'b0, 1'b0, 13'h0040, 8'h00, 1, 8'h3C};
      tbl[7] = '{1'b1, 1'b0, 13'h0040, 8'h00, 3, 8'h3C};
      tbl[8] = '{1'b1, 1'b0, 13'h0041, 8'h00, 3, 8'h82};

      // Reset state
      repeat (2) @(posedge clock);
      @(negedge clock);
      checkEq("rst_ack", 32'(cpu_ack), 32'd0);
      checkEq("rst_q", 32'(cpu_q), 32'd0);
      checkEq("rst_we", 32'(ram_we), 32'd0);
      checkEq("rst_fetches", 32'(dut.r_videoFetches), 32'd0);
      checkEq("rst_state", 32'(dut.r_state), 32'(ST_IDLE));
      @(posedge clock);
      #1 reset = 1'b0;
      monEn = 1'b1;
      @(posedge clock);
      #1;

      // Directed vectors
      foreach (tbl[i]) begin
         video_busy = tbl[i].busy;
         @(posedge clock);
         #1;
         doOp(tbl[i].wr, tbl[i].a, tbl[i].d, lat, q);
         checkEq($sformatf("vec%0d_lat", i), 32'(lat), 32'(tbl[i].lat));
         if (!tbl[i].wr) checkEq($sformatf("vec%0d_q", i), 32'(q), 32'(tbl[i].q));
      end
      checkEq("vec_log_size", 32'(ramLog.size()), 32'd3);
      if (ramLog.size() >= 3) begin
         checkEq("vec_log0", 32'(ramLog[0]), {11'd0, 13'h0123, 8'hA5});
         checkEq("vec_log1", 32'(ramLog[1]), {11'd0, 13'h1FFF, 8'h5A});
         checkEq("vec_log2", 32'(ramLog[2]), {11'd0, 13'h0040, 8'h3C});
      end

      // Read held off by a 12-cycle video window
      cpu_wr = 1'b0;
      cpu_a  = 13'h1800;
      for (int k = 0; k < 12; k++) begin
         video_busy = 1'b0;
         video_a    = 13'($urandom);
         if (k == 2) cpu_req = 1'b1;
         @(negedge clock);
         checkEq("win_no_ack", 32'(cpu_ack), 32'd0);
         @(posedge clock);
         #1;
      end
      video_busy = 1'b1;
      n = 0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clock);
         n++;
         @(negedge clock);
         if (cpu_ack === 1'b1) break;
      end
      checkEq("win_lat", 32'(n), 32'd2);
      checkEq("win_q", 32'(cpu_q), 32'(golden[13'h1800]));
      @(posedge clock);
      #1 cpu_req = 1'b0;
      @(posedge clock);
      #1;

      // Back-to-back writes inside a video window
      video_busy = 1'b0;
      @(posedge clock);
      #1;
      sz = ramLog.size();
      doOp(1'b1, 13'h0100, 8'h11, lat, q);
      checkEq("b2b_lat1", 32'(lat), 32'd1);
      fork
         doOp(1'b1, 13'h0101, 8'h22, lat, q);
         begin
            repeat (5) @(posedge clock);
            #1 video_busy = 1'b1;
         end
      join
      checkEq("b2b_lat2", 32'(lat), 32'd6);
      checkEq("b2b_log_size", 32'(ramLog.size()), 32'(sz + 2));
      if (ramLog.size() == sz + 2) begin
         checkEq("b2b_first", 32'(ramLog[sz]), {11'd0, 13'h0100, 8'h11});
         checkEq("b2b_second", 32'(ramLog[sz + 1]), {11'd0, 13'h0101, 8'h22});
      end

      // Reset while a read waits behind a buffered write
      video_busy = 1'b0;
      @(posedge clock);
      #1;
      cpuOp(1'b1, 13'h0200, 8'h99, lat, q, ok);
      checkEq("rsttx_wr_lat", 32'(lat), 32'd1);
      cpu_wr  = 1'b0;
      cpu_a   = 13'h0300;
      cpu_req = 1'b1;
      @(posedge clock);
      @(negedge clock);
      checkEq("rsttx_state", 32'(dut.r_state), 32'(ST_RD_ISSUE));
      #2;
      reset      = 1'b1;
      video_busy = 1'b1;
      cpu_req    = 1'b0;
      #1;
      checkEq("rsttx_ack", 32'(cpu_ack), 32'd0);
      checkEq("rsttx_we", 32'(ram_we), 32'd0);
      checkEq("rsttx_idle", 32'(dut.r_state), 32'(ST_IDLE));
      @(posedge clock);
      #1 reset = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      checkEq("rsttx_discard", 32'(bram[13'h0200]), 32'(golden[13'h0200]));
      checkEq("rsttx_q", 32'(cpu_q), 32'd0);

      // Scaled raster with random CPU traffic
      fetchCnt = 0;
      fork
         begin
            logic [12:0] vaddr;
            vaddr = '0;
            for (int line = 0; line < LINES; line++) begin
               for (int x = 0; x < 448; x++) begin
                  video_busy = (line % 10 == 9) || (x >= 320);
                  video_read = !video_busy && (x % 4 == 3);
                  video_a    = vaddr;
                  if (video_read) begin
                     fetchCnt++;
                     vaddr = vaddr + 13'd1;
                  end
                  @(posedge clock);
                  #1;
               end
            end
            video_busy = 1'b1;
            video_read = 1'b0;
            videoDone  = 1'b1;
         end
         begin
            bit          rw;
            logic [12:0] ra;
            logic [7:0]  rd;
            logic [7:0]  rq;
            int          rl;
            logic [7:0]  expQ;
            while (!videoDone) begin
               rw = 1'($urandom_range(0, 1));
               ra = 13'h1FF0 + 13'($urandom_range(0, 31));
               rd = 8'($urandom);
               expQ = golden[ra];
               doOp(rw, ra, rd, rl, rq);
               if (!rw) checkEq("rnd_q", 32'(rq), 32'(expQ));
               if ($urandom_range(0, 3) == 0) begin
                  @(posedge clock);
                  #1;
               end
            end
         end
      join
      repeat (4) @(posedge clock);
      #1;
      checkEq("fetch_count", 32'(dut.r_videoFetches), 32'(16'(fetchCnt)));
      checkEq("log_size", 32'(ramLog.size()), 32'(issued.size()));
      bad = 0;
      for (int i = 0; i < ramLog.size() && i < issued.size(); i++) begin
         if (ramLog[i] !== issued[i]) bad++;
      end
      checkEq("log_order", 32'(bad), 32'd0);
      bad = 0;
      for (int i = 0; i < 8192; i++) begin
         if (bram[i] !== golden[i]) bad++;
      end
      checkEq("mem_image", 32'(bad), 32'd0);

      monEn = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
      $finish;
   end

endmodule
`default_nettype wire
